acc3_decoder: RTL



---
 rtl/acc3_pkg.sv | 36 +++
 rtl/acc3_decoder_diff.sv | 27 ++
 rtl/acc3_decoder.sv | 79 +++++++
 3 files changed

// File: rtl/acc3_pkg.sv
// acc3_pkg -- shared definitions for the triple-accumulator decoder.
//   ACC_W / DATA_W : sample and nibble widths.
//   state_e        : decoder FSM states.
//   mirror_t       : mirror of the encoder's accumulator state.
//   encode_step()  : one encoder step. The decoder uses it to advance its
//                    mirror, and the bench uses it as the golden encoder.
package acc3_pkg;

  localparam int ACC_W  = 8;
  localparam int DATA_W = 4;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } state_e;

  typedef struct packed {
    logic [ACC_W-1:0] p_out;  // previous output sample
    logic [ACC_W-1:0] p_s1;   // encoder acc1
    logic [ACC_W-1:0] p_s2;   // encoder acc2
  } mirror_t;

  // Advance the encoder by one nibble; all arithmetic wraps mod 2^ACC_W.
  // The resulting p_out is the sample the encoder emits for d.
  function automatic mirror_t encode_step(input mirror_t m,
                                          input logic [DATA_W-1:0] d);
    mirror_t          r;
    logic [ACC_W-1:0] dw;
    dw      = ACC_W'(d);
    r.p_s1  = m.p_s1 + dw;
    r.p_s2  = m.p_s2 + m.p_s1 + dw;
    r.p_out = m.p_out + (m.p_s1 << 1) + m.p_s2 + (dw << 1);
    return r;
  endfunction

endpackage

// File: rtl/acc3_decoder_diff.sv
// acc3_diff -- combinational differencing stage.
//   sample : incoming accumulator sample.
//   mirror : current mirror of the encoder state.
//   legal  : sample is reachable from the mirror by some 4-bit input.
//   d      : recovered nibble (meaningful only when legal).
module acc3_diff
  import acc3_pkg::*;
(
  input  logic [ACC_W-1:0]  sample,
  input  mirror_t           mirror,
  output logic              legal,
  output logic [DATA_W-1:0] d
);

  logic [ACC_W-1:0] t;

  // NOTE: every output gets a value on every path through always_comb, so
  // no latch can be inferred.
  always_comb begin
    // A legal sample leaves exactly 2*d once the accumulated terms are
    // subtracted, so t must be even and fit in DATA_W+1 bits.
    t     = sample - mirror.p_out - (mirror.p_s1 << 1) - mirror.p_s2;
    legal = (t[0] == 1'b0) && (t[ACC_W-1:DATA_W+1] == '0);
    d     = t[DATA_W:1];
  end

endmodule

// File: rtl/acc3_decoder.sv
// acc3_decoder -- recovers 4-bit data from the triple-accumulator stream.
//   clk, reset          : single clock, synchronous active-high reset.
//   in_data/in_valid/in_ready    : sample input handshake.
//   clear               : resync pulse; zeroes the mirror and leaves ERR.
//   out_data/out_valid/out_ready : nibble output handshake.
//   err                 : sticky decode error.
//   count               : nibbles delivered, wraps modulo 2^CNT_W.
module acc3_decoder
  import acc3_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ACC_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err,
  output logic [CNT_W-1:0]  count
);

  state_e            state;
  mirror_t           mirror;
  logic              legal;
  logic [DATA_W-1:0] d;
  logic              accept;

  acc3_diff u_diff (
    .sample (in_data),
    .mirror (mirror),
    .legal  (legal),
    .d      (d)
  );

  // ERR swallows samples, so it never back-pressures; in RUN the single
  // output register frees up whenever it is empty or being drained.
  assign in_ready = (state == ERR) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      mirror    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
    end else begin
      // Drain first; a reload below in the same cycle overrides it.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (clear) begin
        // A sample accepted alongside clear is dropped; a pending output
        // nibble is left in place for delivery.
        state  <= RUN;
        mirror <= '0;
        err    <= 1'b0;
      end else if (accept && state == RUN) begin
        if (legal) begin
          out_data  <= d;
          out_valid <= 1'b1;
          mirror    <= encode_step(mirror, d);
          count     <= count + 1'b1;
        end else begin
          err   <= 1'b1;
          state <= ERR;
        end
      end
    end
  end

endmodule
